// File: rtl/windowed_register_file_if.sv
// rtl/windowed_register_file_if.sv - read/write ports and window control of the windowed register file
interface windowed_register_file_if #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CW       = $clog2(NWINDOWS)
);
  logic [4:0]          RA, RB, RD, RW;
  logic [WIDTH-1:0]    PA, PB, PD, PW;
  logic                LE;
  logic                save, restore;
  logic                cwp_we;
  logic [CW-1:0]       cwp_in, cwp;
  logic                wim_we;
  logic [NWINDOWS-1:0] wim_in, wim;
  logic                win_ovf, win_unf;

  modport master (
    output RA, RB, RD, RW, PW, LE, save, restore, cwp_we, cwp_in, wim_we, wim_in,
    input  PA, PB, PD, cwp, wim, win_ovf, win_unf
  );

  modport slave (
    input  RA, RB, RD, RW, PW, LE, save, restore, cwp_we, cwp_in, wim_we, wim_in,
    output PA, PB, PD, cwp, wim, win_ovf, win_unf
  );
endinterface

// File: rtl/windowed_register_file.sv
// rtl/windowed_register_file.sv - SPARC windowed register file with CWP/WIM and SAVE/RESTORE traps
module windowed_register_file #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CW       = $clog2(NWINDOWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  windowed_register_file_if.slave bus
);
  localparam int NPHYS = 8 + 16 * NWINDOWS;
  localparam int AW    = $clog2(NPHYS);
  localparam int RING  = 16 * NWINDOWS;

  logic [WIDTH-1:0]    regs [NPHYS];
  logic [CW-1:0]       cwp_q, cwp_nxt, cwp_dec, cwp_inc, cwp_load;
  logic [NWINDOWS-1:0] wim_q;
  logic                ovf_q, unf_q, ovf_nxt, unf_nxt;

  // Windowed registers live on a ring of 16*NWINDOWS entries above the globals;
  // the sum never exceeds one ring length past the end, so one fold suffices.
  function automatic logic [AW-1:0] phys_idx(input logic [4:0] r, input logic [CW-1:0] w);
    int s;
    if (r < 5'd8) return AW'(r);
    s = 16 * int'(w) + int'(r) - 8;
    if (s >= RING) s = s - RING;
    return AW'(s + 8);
  endfunction

  assign bus.PA = (bus.RA == 5'd0) ? '0 : regs[phys_idx(bus.RA, cwp_q)];
  assign bus.PB = (bus.RB == 5'd0) ? '0 : regs[phys_idx(bus.RB, cwp_q)];
  assign bus.PD = (bus.RD == 5'd0) ? '0 : regs[phys_idx(bus.RD, cwp_q)];

  assign cwp_dec  = (cwp_q == '0) ? CW'(NWINDOWS - 1) : cwp_q - 1'b1;
  assign cwp_inc  = (int'(cwp_q) == NWINDOWS - 1) ? '0 : cwp_q + 1'b1;
  assign cwp_load = (int'(bus.cwp_in) >= NWINDOWS) ? CW'(int'(bus.cwp_in) - NWINDOWS) : bus.cwp_in;

  always_comb begin
    cwp_nxt = cwp_q;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (bus.cwp_we) begin
      cwp_nxt = cwp_load;
    end else if (bus.save && !bus.restore) begin
      if (wim_q[cwp_dec]) ovf_nxt = 1'b1;
      else                cwp_nxt = cwp_dec;
    end else if (bus.restore && !bus.save) begin
      if (wim_q[cwp_inc]) unf_nxt = 1'b1;
      else                unf_nxt = 1'b0;
      if (!wim_q[cwp_inc]) cwp_nxt = cwp_inc;
    end
  end

  // Writes index with the pre-edge CWP so a write paired with SAVE/RESTORE lands in the old window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp_q <= '0;
      wim_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
    end else begin
      cwp_q <= cwp_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
      if (bus.wim_we) wim_q <= bus.wim_in;
      if (bus.LE && bus.RW != 5'd0) regs[phys_idx(bus.RW, cwp_q)] <= bus.PW;
    end
  end

  assign bus.cwp     = cwp_q;
  assign bus.wim     = wim_q;
  assign bus.win_ovf = ovf_q;
  assign bus.win_unf = unf_q;
endmodule

// File: tb/tb_windowed_register_file.sv
// tb/tb_windowed_register_file.sv - table, corner-sequence and randomized checks of windowed_register_file
module tb_windowed_register_file;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  windowed_register_file_if #(.WIDTH(32), .NWINDOWS(NW)) bus();
  windowed_register_file #(.WIDTH(32), .NWINDOWS(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0]  ra, rw;
    logic [31:0] pw;
    logic        le, sv, rs, cwe;
    logic [2:0]  cin;
    logic        wwe;
    logic [7:0]  win;
    logic [31:0] exp_pa;
    logic [2:0]  exp_cwp;
    logic [7:0]  exp_wim;
    logic        exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [8 + 16*NW];
  int          mcwp;
  logic [7:0]  mwim;
  logic        movf, munf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int mphys(input int r, input int w);
    if (r < 8) return r;
    return 8 + (16 * w + r - 8) % (16 * NW);
  endfunction

  task automatic drive(input vec_t v);
    bus.RA = v.ra; bus.RB = v.ra; bus.RD = v.ra;
    bus.RW = v.rw; bus.PW = v.pw; bus.LE = v.le;
    bus.save = v.sv; bus.restore = v.rs;
    bus.cwp_we = v.cwe; bus.cwp_in = v.cin;
    bus.wim_we = v.wwe; bus.wim_in = v.win;
  endtask

  function automatic vec_t mk(input logic [4:0] ra, input logic [4:0] rw, input logic [31:0] pw,
                              input logic le, input logic sv, input logic rs, input logic cwe,
                              input logic [2:0] cin, input logic wwe, input logic [7:0] win,
                              input logic [31:0] pa, input logic [2:0] c, input logic [7:0] w,
                              input logic o, input logic u);
    vec_t v;
    v.ra = ra; v.rw = rw; v.pw = pw; v.le = le; v.sv = sv; v.rs = rs; v.cwe = cwe;
    v.cin = cin; v.wwe = wwe; v.win = win;
    v.exp_pa = pa; v.exp_cwp = c; v.exp_wim = w; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  vec_t idle;

  initial begin
    idle = mk(5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(idle);
    bus.RA = 5'd5; bus.RB = 5'd5; bus.RD = 5'd5;
    #2;
    check("reset_pa", bus.PA, 32'h0);
    check("reset_pb", bus.PB, 32'h0);
    check("reset_pd", bus.PD, 32'h0);
    check("reset_cwp", 32'(bus.cwp), 32'h0);
    check("reset_wim", 32'(bus.wim), 32'h0);
    check("reset_ovf", 32'(bus.win_ovf), 32'h0);
    check("reset_unf", 32'(bus.win_unf), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    //            ra     rw     pw            le    sv    rs    cwe   cin   wwe   win     pa            cwp   wim    ovf   unf
    vecs.push_back(mk(5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd1, 5'd1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'hA5A5A5A5, 3'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd1, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 32'hA5A5A5A5, 3'd2, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd8, 5'd8, 32'h1234,     1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h1234,     3'd2, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd16,5'd16,32'hBEEF,     1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'hBEEF,     3'd2, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd24,5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h1234,     3'd1, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd16,5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd1, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd1, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 32'hA5A5A5A5, 3'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd7, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd1, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h02, 32'hA5A5A5A5, 3'd2, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd2, 8'h02, 1'b1, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd2, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h02, 1'b0, 1'b1));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00, 32'h0,        3'd3, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd16,5'd16,32'h77,       1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'hBEEF,     3'd2, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd16,5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 32'h77,       3'd3, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 32'h0,        3'd5, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h10, 32'h0,        3'd4, 8'h10, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd5, 8'h10, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd5, 8'h10, 1'b1, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd5, 8'h10, 1'b1, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0,        3'd5, 8'h10, 1'b0, 1'b0));
    vecs.push_back(mk(5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 32'h0,        3'd0, 8'h10, 1'b0, 1'b0));
    vecs.push_back(mk(5'd8, 5'd8, 32'hCAFE,     1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'hCAFE,     3'd0, 8'h10, 1'b0, 1'b0));
    vecs.push_back(mk(5'd24,5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 32'hCAFE,     3'd7, 8'h10, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pa", i), bus.PA, vecs[i].exp_pa);
      check($sformatf("vec%0d_cwp", i), 32'(bus.cwp), 32'(vecs[i].exp_cwp));
      check($sformatf("vec%0d_wim", i), 32'(bus.wim), 32'(vecs[i].exp_wim));
      check($sformatf("vec%0d_ovf", i), 32'(bus.win_ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i), 32'(bus.win_unf), 32'(vecs[i].exp_unf));
    end

    // Pending overflow pulse must vanish the moment reset is asserted.
    @(negedge clk);
    drive(mk(5'd1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 32'h0, 3'd0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    drive(mk(5'd1, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 32'h0, 3'd0, 8'h00, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("midrst_pre_ovf", 32'(bus.win_ovf), 32'h1);
    check("midrst_pre_pa", bus.PA, 32'hA5A5A5A5);
    #1;
    drive(idle);
    bus.RA = 5'd1; bus.RB = 5'd24; bus.RD = 5'd8;
    rst_n = 1'b0;
    #1;
    check("midrst_ovf", 32'(bus.win_ovf), 32'h0);
    check("midrst_cwp", 32'(bus.cwp), 32'h0);
    check("midrst_wim", 32'(bus.wim), 32'h0);
    check("midrst_pa", bus.PA, 32'h0);
    check("midrst_pb", bus.PB, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (mem[i]) mem[i] = 32'h0;
    mcwp = 0; mwim = 8'h00; movf = 1'b0; munf = 1'b0;

    for (int n = 0; n < 400; n++) begin
      int t;
      vec_t v;
      v = idle;
      v.ra  = 5'($urandom);
      v.rw  = 5'($urandom);
      v.pw  = $urandom;
      v.le  = 1'($urandom);
      v.sv  = ($urandom_range(0, 3) == 0);
      v.rs  = ($urandom_range(0, 3) == 0);
      v.cwe = ($urandom_range(0, 15) == 0);
      v.cin = 3'($urandom);
      v.wwe = ($urandom_range(0, 15) == 0);
      v.win = 8'($urandom & $urandom & $urandom);
      @(negedge clk);
      drive(v);
      bus.RB = 5'($urandom);
      bus.RD = 5'($urandom);
      #1;
      check("rnd_pa", bus.PA, (v.ra == 5'd0) ? 32'h0 : mem[mphys(int'(v.ra), mcwp)]);
      check("rnd_pb", bus.PB, (bus.RB == 5'd0) ? 32'h0 : mem[mphys(int'(bus.RB), mcwp)]);
      check("rnd_pd", bus.PD, (bus.RD == 5'd0) ? 32'h0 : mem[mphys(int'(bus.RD), mcwp)]);
      check("rnd_cwp", 32'(bus.cwp), 32'(mcwp));
      check("rnd_wim", 32'(bus.wim), 32'(mwim));
      check("rnd_ovf", 32'(bus.win_ovf), 32'(movf));
      check("rnd_unf", 32'(bus.win_unf), 32'(munf));
      @(posedge clk);
      if (v.le && v.rw != 5'd0) mem[mphys(int'(v.rw), mcwp)] = v.pw;
      movf = 1'b0; munf = 1'b0;
      if (v.cwe) begin
        mcwp = int'(v.cin) % NW;
      end else if (v.sv && !v.rs) begin
        t = (mcwp + NW - 1) % NW;
        if (mwim[t]) movf = 1'b1; else mcwp = t;
      end else if (v.rs && !v.sv) begin
        t = (mcwp + 1) % NW;
        if (mwim[t]) munf = 1'b1; else mcwp = t;
      end
      if (v.wwe) mwim = v.win;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/windowed_register_file.md
# windowed_register_file

Parametrised SPARC windowed integer register file that generalises the flat 32×32 three-port file. It holds 8 globals plus NWINDOWS overlapping windows of 16 registers each. Every window provides its own locals and shares its ins/outs with the neighbouring windows. It contains its own current-window pointer (CWP) and window-invalid mask (WIM), executes SAVE/RESTORE, and flags window overflow/underflow to the trap logic. It sits in the decode/writeback stage in place of the flat register file, with the same asynchronous-read, synchronous-write port model.

## Interface
- WIDTH, 32, data width of every register and port
- NWINDOWS, 8, number of register windows, legal range 2..32 (need not be a power of two)
- CW, $clog2(NWINDOWS), width of the CWP
---
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset is asynchronous and active-low
- RA, RB, RD  in  5 each  logical read selects for ports A, B, D
- PA, PB, PD  out  WIDTH each  combinational read data
- RW  in  5  logical write select
- PW  in  WIDTH  write data
- LE  in  1  write enable
- save  in  1  SAVE request: decrement CWP
- restore  in  1  RESTORE request: increment CWP
- cwp_we  in  1  direct CWP load (WRPSR)
- cwp_in  in  CW  value for the direct CWP load
- wim_we  in  1  WIM load (WRWIM)
- wim_in  in  NWINDOWS  value for the WIM load
- cwp  out  CW  current window pointer
- wim  out  NWINDOWS  current window-invalid mask
- win_ovf  out  1  one-cycle pulse: SAVE was blocked by WIM
- win_unf  out  1  one-cycle pulse: RESTORE was blocked by WIM

## Operation
- Physical storage: 8 + 16·NWINDOWS registers of WIDTH bits.
- Logical-to-physical mapping for window w:
  - r0..r7 (globals) map to phys 0..7, independent of w.
  - r8..r31 map to phys 8 + ((16·w + (r−8)) mod 16·NWINDOWS).
  - Consequence: the ins (r24..31) of window w are the outs (r8..15) of window (w+1) mod NWINDOWS.
- Reads are asynchronous. The current CWP and register contents appear on PA/PB/PD in the same cycle the select changes.
- r0 always reads 0. A write to r0 is discarded.
- Write: on a rising edge with LE=1, PW is stored in the physical register that RW maps to under the CWP value *before* that edge.
- CWP update, evaluated each edge in priority order:
  1. cwp_we=1: CWP ← cwp_in. If cwp_in ≥ NWINDOWS, CWP ← cwp_in mod NWINDOWS. save/restore are ignored.
  2. save and restore both 1: no CWP change and no trap pulse.
  3. save=1:
     - Let t = (CWP−1) mod NWINDOWS, so 0 wraps to NWINDOWS−1.
     - If wim[t]=1: CWP is unchanged and win_ovf=1 for the next cycle.
     - Otherwise CWP ← t.
  4. restore=1:
     - Let t = (CWP+1) mod NWINDOWS, so NWINDOWS−1 wraps to 0.
     - If wim[t]=1: CWP is unchanged and win_unf=1 for the next cycle.
     - Otherwise CWP ← t.
- WIM: on an edge with wim_we=1, WIM ← wim_in. A WIM check in the same cycle uses the old WIM.

## Timing
- Reset (rst_n=0, asynchronous), held until the first edge after deassertion:
  - all physical registers = 0
  - CWP = 0, WIM = 0
  - win_ovf = 0, win_unf = 0
  - PA/PB/PD therefore read 0
- Read latency 0 cycles. Write-to-read latency 1 edge; there is no write-through bypass.
- A write and a save/restore in the same cycle:
  - the write lands in the old window;
  - reads after the edge use the new window.
- win_ovf/win_unf are registered and high for exactly one cycle after the blocked request. They clear on the next edge unless another blocked request occurs.
- Reset asserted mid-operation aborts everything immediately and discards any pending trap pulse.

## Test plan
- Reset, then RA=RB=RD=5 → PA=PB=PD=0, cwp=0, wim=0, no trap pulse.
- RW=0, PW=FFFF_FFFF, LE=1 → PA reads 0 for RA=0. RW=1, PW=A5A5_A5A5 → PA=A5A5_A5A5 for RA=1 in every window.
- At CWP=2, write r8 (out0) = 1234 → save → CWP=1, and r24 (in0) reads 1234. r16 written at CWP=2 is not visible at CWP=1.
- NWINDOWS=8, CWP=0, save → CWP=7 (wrap). restore → CWP=0. save and restore together → CWP unchanged, no pulse.
- wim=8'b0000_0010, CWP=2, save → CWP stays 2, win_ovf high one cycle. From CWP=0, restore → CWP stays 0, win_unf high one cycle.
- LE=1, RW=16, PW=77 with save in the same cycle at CWP=3 → after the edge CWP=2. Setting cwp_in=3, cwp_we=1 then shows r16=77. cwp_we with save together → CWP=cwp_in, no win_ovf.
